request_arbiter_unit: RTL
=========================

# request_arbiter_unit

Parametrised data/instruction memory request unit for the multicycle/pipelined MIPS datapath. Sits between up to NCH data requestors (pipeline memory stage, extra load/store ports) and the single memory port. Latches one read or write request at a time, holds the dmem enables until `dhit`, and arbitrates round-robin across channels. Adds a stuck-request timeout, halt handling, and an optional data-priority mode that gates instruction fetch.

## Interface
- NCH, default 2: number of data requestor channels, ≥1.
- TIMEOUT, default 0: cycles in BUSY before abort; 0 disables the timeout.
- DPRIORITY, default 0: 1 deasserts `imemREN` while a data access is in flight.
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- ihit  input  1  instruction memory access complete; informational only.
- dhit  input  1  data memory access complete.
- memRdRq  input  NCH  per-channel read request level.
- memWrRq  input  NCH  per-channel write request level.
- halt  input  1  processor halt seen.
- dmemREN  output  1  data read enable to memory.
- dmemWEN  output  1  data write enable to memory.
- imemREN  output  1  instruction read enable.
- grant  output  NCH  one-hot channel currently owning the data port.
- busy  output  1  data access in flight.
- halted  output  1  unit in HALTED state.
- timeout_err  output  1  sticky; set when a request is aborted.
- proto_err  output  1  sticky; set when a channel asserts rd and wr together.

## Operation
- All outputs are registered. Reset values: dmemREN=0, dmemWEN=0, imemREN=0, grant=0, busy=0, halted=0, timeout_err=0, proto_err=0; RR pointer=0; timeout counter=0; state IDLE.
- States are IDLE, BUSY and HALTED.
- IDLE:
  - If `halt`=1, go to HALTED. Halt has priority over new requests.
  - Otherwise req[i] = memRdRq[i] | memWrRq[i], excluding the masked channel.
  - The winner is the first requesting channel at or after the pointer, scanning upward with wrap modulo NCH.
  - On a winner: grant = one-hot(winner); dmemWEN = memWrRq[winner]; dmemREN = ~memWrRq[winner]; busy=1; go to BUSY.
  - Rd and wr together on the winner: the write wins and proto_err is set.
- BUSY:
  - grant and the enable stay frozen, whatever the request inputs do.
  - On `dhit`: clear the enables, grant and busy; pointer = winner+1 mod NCH; mask the winner for exactly the next IDLE cycle; go to IDLE.
  - With TIMEOUT>0: the counter increments each BUSY cycle without `dhit`. When count reaches TIMEOUT-1 and `dhit`=0, the access aborts. Abort does the same clear and pointer update as `dhit`, and also sets timeout_err.
  - `dhit` on the same cycle as the timeout threshold counts as completion, not abort.
  - `halt` seen during BUSY is recorded and acted on in the next IDLE cycle.
- HALTED:
  - imemREN=0 and halted=1. Data requests are ignored.
  - Exit only through RST.
- imemREN:
  - 1 from the first cycle after reset release, except in HALTED.
  - With DPRIORITY=1 it is also 0 during BUSY.
- dhit outside BUSY is ignored. NCH=1 makes the pointer a constant 0; the mask still applies.
- Pointer width is max(1, clog2(NCH)). Counter width is max(1, clog2(TIMEOUT+1)).

## Timing
- Request sampled at edge N: enable and grant are high after edge N+1 and stay high through the cycle in which `dhit` is 1.
- `dhit` at edge M: enables are low from M onward.
- A different channel can be granted at the earliest by edge M+1. The same channel can be granted again at the earliest by edge M+2.
- Back-to-back throughput: one access per (memory latency + 1) cycles.
- RST asserted mid-access: all outputs return to reset values after that edge; no completion or abort is recorded.
- halt+RST together: reset wins.

## Test plan
- NCH=2. Channel 0 raises memRdRq; `dhit` arrives 3 cycles later -> dmemREN=1 and grant=01 for 3 cycles, then 0; busy follows the same window; dmemWEN stays 0.
- NCH=4, pointer=0. Channels 1 and 3 request continuously and return `dhit` after 1 cycle -> grant sequence 0010, 1000, 0010, with exactly one idle cycle between grants.
- TIMEOUT=5. Channel 0 writes and `dhit` never arrives -> dmemWEN high 5 cycles then drops; timeout_err=1 stays set; the next request is granted normally.
- Channel 0 asserts memRdRq and memWrRq together -> dmemWEN=1, dmemREN=0, proto_err=1.
- `halt` during BUSY -> the access completes on `dhit`; next cycle halted=1 and imemREN=0; later requests get no grant until RST.
- DPRIORITY=1 -> imemREN=0 exactly during busy. RST pulsed during BUSY -> all outputs 0 the next cycle and imemREN=1 after release.

Source files
------------

// File: rtl/request_arbiter_unit_if.sv
// Memory-side bundle of the data-port arbiter: per-channel requests, dmem/imem enables and status.
// The arbiter takes the slave view; the requestor/memory environment takes the master view.
interface request_arbiter_unit_if #(
    parameter int NCH = 2
);
    logic           ihit;
    logic           dhit;
    logic [NCH-1:0] memRdRq;
    logic [NCH-1:0] memWrRq;
    logic           halt;
    logic           dmemREN;
    logic           dmemWEN;
    logic           imemREN;
    logic [NCH-1:0] grant;
    logic           busy;
    logic           halted;
    logic           timeout_err;
    logic           proto_err;

    modport master (
        output ihit, dhit, memRdRq, memWrRq, halt,
        input  dmemREN, dmemWEN, imemREN, grant, busy, halted, timeout_err, proto_err
    );

    modport slave (
        input  ihit, dhit, memRdRq, memWrRq, halt,
        output dmemREN, dmemWEN, imemREN, grant, busy, halted, timeout_err, proto_err
    );
endinterface

// File: rtl/request_arbiter_unit.sv
// Round-robin owner of the single data memory port; enables held until dhit or timeout abort, plus halt.
// Latency: grant one cycle after a request; losing channels keep requesting and are served in rotation.
module request_arbiter_unit #(
    parameter int NCH       = 2,
    parameter int TIMEOUT   = 0,
    parameter int DPRIORITY = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    request_arbiter_unit_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] LAST_CH  = PW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d, win_q, win_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] mask_q, mask_d, grant_q, grant_d;
    logic           halt_pend_q, halt_pend_d;
    logic           ren_q, ren_d, wen_q, wen_d, imem_q, imem_d;
    logic           busy_q, busy_d, halted_q, halted_d;
    logic           terr_q, terr_d, perr_q, perr_d;

    logic [NCH-1:0] req, win_oh;
    logic [PW-1:0]  hi_idx, lo_idx, win_idx;
    logic           hi_vld, lo_vld, win_vld, win_rd, win_wr, timeout_hit;
    logic           unused_ihit;

    assign unused_ihit = bus.ihit;

    // Lowest requester at/above the pointer wins; otherwise lowest one below it (wrap).
    always_comb begin
        req    = (bus.memRdRq | bus.memWrRq) & ~mask_q;
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (PW'(i) >= ptr_q) begin
                    hi_idx = PW'(i);
                    hi_vld = 1'b1;
                end else begin
                    lo_idx = PW'(i);
                    lo_vld = 1'b1;
                end
            end
        end
        win_vld = hi_vld | lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
        win_oh  = NCH'(1) << win_idx;
        win_rd  = |(bus.memRdRq & win_oh);
        win_wr  = |(bus.memWrRq & win_oh);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        mask_d      = '0;
        grant_d     = grant_q;
        halt_pend_d = halt_pend_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        terr_d      = terr_q;
        perr_d      = perr_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.halt || halt_pend_q) begin
                    state_d = S_HALTED;
                end else if (win_vld) begin
                    state_d = S_BUSY;
                    win_d   = win_idx;
                    grant_d = win_oh;
                    wen_d   = win_wr;
                    ren_d   = ~win_wr;
                    cnt_d   = '0;
                    if (win_rd && win_wr) perr_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus.halt) halt_pend_d = 1'b1;
                timeout_hit = (TIMEOUT > 0) && !bus.dhit && (cnt_q == CNT_LAST);
                if (bus.dhit || timeout_hit) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    cnt_d   = '0;
                    mask_d  = grant_q;
                    ptr_d   = (win_q == LAST_CH) ? '0 : win_q + PW'(1);
                    if (timeout_hit) terr_d = 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
        busy_d   = (state_d == S_BUSY);
        halted_d = (state_d == S_HALTED);
        imem_d   = !halted_d && !((DPRIORITY != 0) && busy_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            grant_q     <= '0;
            halt_pend_q <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            imem_q      <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            terr_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            grant_q     <= grant_d;
            halt_pend_q <= halt_pend_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            imem_q      <= imem_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            terr_q      <= terr_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.dmemREN     = ren_q;
    assign bus.dmemWEN     = wen_q;
    assign bus.imemREN     = imem_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.timeout_err = terr_q;
    assign bus.proto_err   = perr_q;
endmodule
